mem_port_arbiter: RTL and testbench

- Shares the core's single-ported memory between two requesters: instruction fetch (IF) and load/store (LS).
- LS has priority, with a starvation guard that guarantees IF forward progress.
- Each granted transaction runs a req/ack handshake with variable-latency memory.
- A response timeout substitutes a safe result and raises a sticky error.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (IF) and load/store (LS). LS has priority, and a starvation counter forces an
// IF grant after STARVE_MAX back-to-back LS grants while IF waits. Every granted
// access runs a req/ack handshake with the memory. If no ack arrives within
// TIMEOUT cycles, the access is aborted and a safe result is returned.
module mem_port_arbiter #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                STARVE_MAX = 4,
   parameter int                TIMEOUT    = 255,
   parameter logic [DATA_W-1:0] IF_FILL    = DATA_W'(32'h00000013)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              timeout_err
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state, state_next;
   logic            owner_ls;     // 1: current transaction belongs to LS
   logic [SW-1:0]   starve_cnt;
   logic [7:0]      tmo_cnt;
   logic            any_req;
   logic            grant_ls;
   logic            tmo_last;

   // IF is forced through once LS has won STARVE_MAX times in a row while IF waited.
   assign any_req  = if_req | ls_req;
   assign grant_ls = ls_req && !(if_req && (starve_cnt == SW'(STARVE_MAX)));
   // The WAIT cycle in which the counter would reach TIMEOUT is the abort cycle.
   assign tmo_last = (tmo_cnt == 8'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: the default assignment first keeps this block free of inferred latches.
      state_next = state;
      case (state)
         S_IDLE:  if (any_req) state_next = S_WAIT;
         S_WAIT:  if (mem_ack || tmo_last) state_next = S_RESP;
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Registered outputs, capture registers and the starvation and timeout counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_ls    <= 1'b0;
         starve_cnt  <= '0;
         tmo_cnt     <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_rdata    <= '0;
         if_valid    <= 1'b0;
         ls_rdata    <= '0;
         ls_valid    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // The valid pulses last one cycle; they are only set on the WAIT->RESP edge.
         if_valid <= 1'b0;
         ls_valid <= 1'b0;
         busy     <= (state_next != S_IDLE);
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  owner_ls  <= grant_ls;
                  mem_req   <= 1'b1;
                  tmo_cnt   <= '0;
                  mem_addr  <= grant_ls ? ls_addr  : if_addr;
                  mem_we    <= grant_ls ? ls_we    : 1'b0;
                  mem_wdata <= grant_ls ? ls_wdata : '0;
                  if (grant_ls && if_req) starve_cnt <= starve_cnt + 1'b1;
                  else                    starve_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  // An ack on the last WAIT cycle takes precedence over the timeout.
                  mem_req <= 1'b0;
                  if (owner_ls) begin
                     ls_rdata <= mem_we ? '0 : mem_rdata;
                     ls_valid <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end
               end else if (tmo_last) begin
                  mem_req     <= 1'b0;
                  timeout_err <= 1'b1;
                  if (owner_ls) begin
                     ls_rdata <= '0;
                     ls_valid <= 1'b1;
                  end else begin
                     if_rdata <= IF_FILL;
                     if_valid <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It covers reset, single fetch, store,
// contention with load, the starvation guard, timeout with a late ack, and
// reset during WAIT.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        timeout_err;

   int total  = 0;
   int passed = 0;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8), .IF_FILL(32'h00000013)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rdata(ls_rdata), .ls_valid(ls_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      logic [31:0] order [6];
      order[0] = 32'h200; order[1] = 32'h200; order[2] = 32'h200;
      order[3] = 32'h200; order[4] = 32'h100; order[5] = 32'h200;

      // Reset held while inputs toggle.
      rst = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
      ls_addr = '0; ls_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if_req = ~if_req; ls_req = ~ls_req; ls_we = ~ls_we; mem_ack = ~mem_ack;
         if_addr = if_addr + 32'h44; ls_wdata = ls_wdata + 32'h5; mem_rdata = ~mem_rdata;
      end
      #1;
      check("rst_outs", {if_rdata | ls_rdata | mem_addr | mem_wdata},  32'h0);
      check("rst_bits", {26'b0, if_valid, ls_valid, mem_req, mem_we, busy, timeout_err}, 32'h0);
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      rst = 1'b1;
      tick();
      check("idle_busy", busy, 1'b0);
      check("idle_req", mem_req, 1'b0);

      // Single fetch, ack two cycles after mem_req rises.
      if_req = 1'b1; if_addr = 32'h10;
      tick();
      check("f_req", mem_req, 1'b1);
      check("f_addr", mem_addr, 32'h10);
      check("f_we", mem_we, 1'b0);
      check("f_busy", busy, 1'b1);
      tick();
      check("f_wait_req", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h00A00093;
      tick();
      check("f_valid", if_valid, 1'b1);
      check("f_rdata", if_rdata, 32'h00A00093);
      check("f_ls_valid", ls_valid, 1'b0);
      check("f_req_drop", mem_req, 1'b0);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();
      check("f_valid_clr", if_valid, 1'b0);
      check("f_idle", busy, 1'b0);

      // Store.
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h3ffff; ls_wdata = 32'hD;
      tick();
      check("s_we", mem_we, 1'b1);
      check("s_wdata", mem_wdata, 32'hD);
      check("s_addr", mem_addr, 32'h3ffff);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      check("s_valid", ls_valid, 1'b1);
      check("s_rdata", ls_rdata, 32'h0);
      check("s_if_valid", if_valid, 1'b0);
      ls_req = 1'b0; ls_we = 1'b0; mem_ack = 1'b0;
      tick();
      check("s_valid_clr", ls_valid, 1'b0);

      // Contention: LS load first, IF in the next arbitration.
      if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_addr = 32'h20;
      tick();
      check("c_ls_addr", mem_addr, 32'h20);
      check("c_ls_we", mem_we, 1'b0);
      check("c_ls_wdata", mem_wdata, 32'hD);
      mem_ack = 1'b1; mem_rdata = 32'h3ffff;
      tick();
      check("c_ls_valid", ls_valid, 1'b1);
      check("c_ls_rdata", ls_rdata, 32'h3ffff);
      check("c_if_idle", if_valid, 1'b0);
      ls_req = 1'b0; mem_ack = 1'b0;
      tick();
      check("c_resp_idle", busy, 1'b0);
      tick();
      check("c_if_addr", mem_addr, 32'h40);
      check("c_if_wdata", mem_wdata, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h11111111;
      tick();
      check("c_if_valid", if_valid, 1'b1);
      check("c_if_rdata", if_rdata, 32'h11111111);
      check("c_ls_rdata_hold", ls_rdata, 32'h3ffff);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();

      // Starvation guard: both requests held, 1-cycle ack.
      if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_addr = 32'h200; ls_we = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h55;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("st_grant%0d", i), mem_addr, order[i]);
         tick();
         check($sformatf("st_valid%0d", i), {30'b0, if_valid, ls_valid},
               (order[i] == 32'h100) ? 32'h2 : 32'h1);
         tick();
      end
      if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
      tick();
      check("st_idle", busy, 1'b0);

      // Timeout on a fetch that never gets an ack.
      check("t_err_pre", timeout_err, 1'b0);
      if_req = 1'b1; if_addr = 32'h300;
      tick();
      check("t_req", mem_req, 1'b1);
      for (int i = 0; i < 7; i++) tick();
      check("t_req_held", mem_req, 1'b1);
      check("t_no_valid", if_valid, 1'b0);
      tick();
      check("t_req_drop", mem_req, 1'b0);
      check("t_valid", if_valid, 1'b1);
      check("t_fill", if_rdata, 32'h00000013);
      check("t_err", timeout_err, 1'b1);
      if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      tick();
      check("t_late_valid", {30'b0, if_valid, ls_valid}, 32'h0);
      check("t_late_idle", busy, 1'b0);
      tick();
      check("t_late_req", mem_req, 1'b0);
      check("t_late_rdata", if_rdata, 32'h00000013);
      check("t_err_sticky", timeout_err, 1'b1);
      mem_ack = 1'b0;

      // Reset asserted mid-WAIT abandons the transaction.
      if_req = 1'b1; if_addr = 32'h400;
      tick();
      tick();
      tick();
      check("r_in_wait", busy, 1'b1);
      rst = 1'b0;
      #1;
      check("r_err", timeout_err, 1'b0);
      check("r_req", mem_req, 1'b0);
      check("r_busy", busy, 1'b0);
      check("r_addr", mem_addr, 32'h0);
      check("r_rdata", if_rdata, 32'h0);
      if_req = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("r_no_valid%0d", i), {30'b0, if_valid, ls_valid}, 32'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
